// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFin
    } div_state_e;

    // Bits needed to hold values 0..n-1 (at least 1 for n >= 2).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/add_sub_n.sv
// N-bit ripple-carry adder/subtractor; op_i=1 inverts b and injects carry-in for a - b.
module add_sub_n #(
    parameter int unsigned N = 5
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         op_i,
    output logic [N-1:0] s_o,
    output logic         cout_o
);

    logic [N-1:0] bx;
    logic [N:0]   c;

    always_comb begin
        bx   = b_i ^ {N{op_i}};
        c    = '0;
        s_o  = '0;
        c[0] = op_i;
        for (int i = 0; i < N; i++) begin
            s_o[i]   = a_i[i] ^ bx[i] ^ c[i];
            c[i + 1] = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
        end
        // Raw carry: 1 means no borrow when subtracting.
        cout_o = c[N];
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one trial subtraction per clock.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] dq_q, dq_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rmd_q, rmd_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;
    logic             no_borrow;

    add_sub_n #(
        .N (WIDTH + 1)
    ) u_add_sub (
        .a_i    (trial),
        .b_i    ({1'b0, dvs_q}),
        .op_i   (1'b1),
        .s_o    (diff),
        .cout_o (no_borrow)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dq_d    = dq_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        trial   = (rem_q << 1) | {{WIDTH{1'b0}}, dq_q[WIDTH-1]};

        unique case (state_q)
            StIdle, StFin: begin
                if (state_q == StFin) begin
                    state_d = StIdle;
                end
                // FIN accepts a new request exactly like IDLE for back-to-back use.
                if (start_i) begin
                    if (divisor_i != '0) begin
                        state_d = StRun;
                        dq_d    = dividend_i;
                        dvs_d   = divisor_i;
                        rem_d   = '0;
                        count_d = '0;
                        dbz_d   = 1'b0;
                    end else begin
                        state_d = StFin;
                        quot_d  = '1;
                        rmd_d   = dividend_i;
                        dbz_d   = 1'b1;
                    end
                end
            end
            StRun: begin
                dq_d    = {dq_q[WIDTH-2:0], no_borrow};
                rem_d   = no_borrow ? diff : trial;
                count_d = count_q + 1'b1;
                if (count_q == LastCnt) begin
                    state_d = StFin;
                    quot_d  = dq_d;
                    rmd_d   = rem_d[WIDTH-1:0];
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            count_q <= '0;
            dq_q    <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dq_q    <= dq_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = (state_q == StRun);
    assign done_o        = (state_q == StFin);
    assign quotient_o    = quot_q;
    assign remainder_o   = rmd_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of the WIDTH=4 sequential divider.
module tb_seq_divider;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int unsigned n_tests;
    int unsigned n_fail;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .busy_o        (busy),
        .done_o        (done),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; presents the request through the next rising edge (cycle 0).
    task automatic start_op(input int unsigned dd, input int unsigned dv);
        start    = 1'b1;
        dividend = W'(dd);
        divisor  = W'(dv);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Steps through cycles 1..lat on negedges; returns in the done cycle.
    task automatic expect_done(input string tag, input int unsigned lat, input int unsigned eq,
                               input int unsigned er, input int unsigned ez);
        for (int unsigned c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c < lat) begin
                check_eq({tag, " busy"}, 32'(busy), 1);
                check_eq({tag, " early done"}, 32'(done), 0);
            end
        end
        check_eq({tag, " done"}, 32'(done), 1);
        check_eq({tag, " busy at done"}, 32'(busy), 0);
        check_eq({tag, " quotient"}, 32'(quotient), eq);
        check_eq({tag, " remainder"}, 32'(remainder), er);
        check_eq({tag, " div_by_zero"}, 32'(div_by_zero), ez);
    endtask

    initial begin
        int unsigned saw_done;
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;

        repeat (2) @(negedge clk);
        check_eq("reset busy", 32'(busy), 0);
        check_eq("reset done", 32'(done), 0);
        check_eq("reset quotient", 32'(quotient), 0);
        check_eq("reset remainder", 32'(remainder), 0);
        check_eq("reset div_by_zero", 32'(div_by_zero), 0);
        rst = 1'b0;
        @(negedge clk);

        // 13/3 -> 4 r1 in cycle 5, then results hold with done low.
        start_op(13, 3);
        expect_done("13/3", 5, 4, 1, 0);
        @(negedge clk);
        check_eq("13/3 done one cycle", 32'(done), 0);
        check_eq("13/3 quotient held", 32'(quotient), 4);
        check_eq("13/3 remainder held", 32'(remainder), 1);

        // Back-to-back: second request issued in the done cycle of the first.
        start_op(15, 1);
        expect_done("15/1", 5, 15, 0, 0);
        start_op(7, 9);
        expect_done("7/9", 5, 0, 7, 0);

        // Divide by zero: done in cycle 1, busy never asserts.
        @(negedge clk);
        start_op(9, 0);
        expect_done("9/0", 1, 15, 9, 1);
        @(negedge clk);
        check_eq("9/0 busy after", 32'(busy), 0);
        check_eq("9/0 done after", 32'(done), 0);
        check_eq("9/0 flag held", 32'(div_by_zero), 1);

        // Start while busy is ignored.
        start_op(12, 5);
        for (int unsigned c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start_op(1, 1);
            end
            if (c < 5 && c != 2) begin
                check_eq("12/5 busy", 32'(busy), 1);
            end
        end
        check_eq("12/5 done", 32'(done), 1);
        check_eq("12/5 quotient", 32'(quotient), 2);
        check_eq("12/5 remainder", 32'(remainder), 2);
        check_eq("12/5 div_by_zero", 32'(div_by_zero), 0);

        // Reset mid-operation aborts with no done pulse.
        @(negedge clk);
        start_op(14, 4);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_eq("abort busy", 32'(busy), 0);
        check_eq("abort done", 32'(done), 0);
        check_eq("abort quotient", 32'(quotient), 0);
        check_eq("abort remainder", 32'(remainder), 0);
        check_eq("abort div_by_zero", 32'(div_by_zero), 0);
        saw_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check_eq("abort no done pulse", saw_done, 0);
        start_op(14, 4);
        expect_done("14/4", 5, 3, 2, 0);

        // Exhaustive sweep, each request chained into the previous done cycle.
        for (int unsigned dd = 0; dd < 16; dd++) begin
            for (int unsigned dv = 0; dv < 16; dv++) begin
                start_op(dd, dv);
                if (dv != 0) begin
                    expect_done($sformatf("sweep %0d/%0d", dd, dv), 5, dd / dv, dd % dv, 0);
                end else begin
                    expect_done($sformatf("sweep %0d/0", dd), 1, 15, dd, 1);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
